// File: rtl/ram_responder.sv
// Byte-addressed big-endian RAM behind the MFA/MOC handshake, with
// programmable wait states and misalignment rejection.
module ram_responder #(
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  main_clk,
  input  logic                  reset,
  input  logic                  mfa,
  input  logic                  rw,
  input  logic [1:0]            size,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic                  moc,
  output logic                  err
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_WAIT =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  localparam state_t AFTER_CAPTURE = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;

  logic [7:0] memory [0:DEPTH-1];

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  cap_rw_q;
  logic [1:0]            cap_size_q;
  logic [ADDR_WIDTH-1:0] cap_addr_q;
  logic [31:0]           cap_data_q;
  logic                  capture_en;
  logic                  wr_en;
  logic                  moc_d, err_d;
  logic [31:0]           dout_d;
  logic                  bad;
  logic [31:0]           rd_data;
  logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;

  // Byte lane addresses of the captured access (MSB byte first)
  assign a0 = cap_addr_q;
  assign a1 = cap_addr_q + ADDR_WIDTH'(1);
  assign a2 = cap_addr_q + ADDR_WIDTH'(2);
  assign a3 = cap_addr_q + ADDR_WIDTH'(3);

  // Alignment / reserved-size rejection
  always_comb begin
    bad = 1'b0;
    case (cap_size_q)
      2'b00:   bad = 1'b0;
      2'b01:   bad = cap_addr_q[0];
      2'b10:   bad = (cap_addr_q[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
  end

  // Right-justified, zero-extended read data
  always_comb begin
    rd_data = '0;
    case (cap_size_q)
      2'b00:   rd_data = {24'h0, memory[a0]};
      2'b01:   rd_data = {16'h0, memory[a0], memory[a1]};
      default: rd_data = {memory[a0], memory[a1], memory[a2], memory[a3]};
    endcase
  end

  always_ff @(posedge main_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cap_rw_q   <= 1'b0;
      cap_size_q <= '0;
      cap_addr_q <= '0;
      cap_data_q <= '0;
      data_out   <= '0;
      moc        <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_out <= dout_d;
      moc      <= moc_d;
      err      <= err_d;
      if (capture_en) begin
        cap_rw_q   <= rw;
        cap_size_q <= size;
        cap_addr_q <= address;
        cap_data_q <= data_in;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    capture_en = 1'b0;
    wr_en      = 1'b0;
    moc_d      = moc;
    err_d      = err;
    dout_d     = data_out;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (mfa) begin
          capture_en = 1'b1;
          state_d    = AFTER_CAPTURE;
        end
      end
      S_WAIT: begin
        if (!mfa) begin
          state_d = S_IDLE;
        end else if (cnt_q == LAST_WAIT) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ACCESS: begin
        moc_d   = 1'b1;
        err_d   = bad;
        dout_d  = (bad || !cap_rw_q) ? '0 : rd_data;
        wr_en   = !bad && !cap_rw_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!mfa) begin
          moc_d   = 1'b0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Storage is never reset; a write commits only on the ACCESS edge
  always_ff @(posedge main_clk) begin
    if (wr_en) begin
      case (cap_size_q)
        2'b00: memory[a0] <= cap_data_q[7:0];
        2'b01: begin
          memory[a0] <= cap_data_q[15:8];
          memory[a1] <= cap_data_q[7:0];
        end
        default: begin
          memory[a0] <= cap_data_q[31:24];
          memory[a1] <= cap_data_q[23:16];
          memory[a2] <= cap_data_q[15:8];
          memory[a3] <= cap_data_q[7:0];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Directed and randomized checks of ram_responder against a byte-array
// reference model of the big-endian memory and handshake timing.
module tb_ram_responder;

  localparam int unsigned AW = 9;
  localparam int unsigned DP = 512;
  localparam int unsigned WS = 2;

  logic          main_clk = 1'b0;
  logic          reset    = 1'b0;
  logic          mfa      = 1'b0;
  logic          rw       = 1'b0;
  logic [1:0]    size     = '0;
  logic [AW-1:0] address  = '0;
  logic [31:0]   data_in  = '0;
  logic [31:0]   data_out;
  logic          moc;
  logic          err;

  int checks   = 0;
  int failures = 0;
  logic [7:0] model_mem [0:DP-1];

  ram_responder #(.ADDR_WIDTH(AW), .DEPTH(DP), .WAIT_STATES(WS)) dut (
    .main_clk (main_clk),
    .reset    (reset),
    .mfa      (mfa),
    .rw       (rw),
    .size     (size),
    .address  (address),
    .data_in  (data_in),
    .data_out (data_out),
    .moc      (moc),
    .err      (err)
  );

  always #5 main_clk = ~main_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_bad(input logic [1:0] s, input int a);
    int n;
    if (s == 2'b11) return 1'b1;
    n = 1 << s;
    return (a % n) != 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] s, input int a);
    logic [31:0] v;
    v = 0;
    for (int k = 0; k < (1 << s); k++) v = (v << 8) | 32'(model_mem[a + k]);
    return v;
  endfunction

  task automatic model_write(input logic [1:0] s, input int a, input logic [31:0] d);
    int n;
    n = 1 << s;
    for (int k = 0; k < n; k++) model_mem[a + k] = 8'(d >> (8 * (n - 1 - k)));
  endtask

  task automatic check_mem(input string tag);
    int diffs;
    diffs = 0;
    for (int i = 0; i < int'(DP); i++) if (dut.memory[i] !== model_mem[i]) diffs++;
    check(tag, 32'(diffs), 32'd0);
  endtask

  // One full handshake starting #1 after an edge; inputs scrambled after capture
  task automatic req(input logic r, input logic [1:0] s, input int a,
                     input logic [31:0] d, input int hold, input string tag);
    int edges;
    bit e;
    logic [31:0] exp_d;
    logic [31:0] held;
    e     = model_bad(s, a);
    exp_d = (e || !r) ? 32'h0 : model_read(s, a);
    mfa = 1'b1; rw = r; size = s; address = AW'(a); data_in = d;
    @(posedge main_clk); #1;
    rw = $urandom_range(0, 1); size = 2'($urandom); address = AW'($urandom); data_in = $urandom;
    edges = 0;
    while (moc !== 1'b1 && edges < 20) begin
      @(posedge main_clk); #1;
      edges++;
    end
    check({tag, " latency"}, 32'(edges), 32'(WS + 1));
    check({tag, " err"}, 32'(err), 32'(e));
    if (r || e) check({tag, " data"}, data_out, exp_d);
    if (!r && !e) model_write(s, a, d);
    held = data_out;
    for (int i = 0; i < hold; i++) begin
      @(posedge main_clk); #1;
      check({tag, " hold moc"}, 32'(moc), 32'd1);
      check({tag, " hold data"}, data_out, held);
    end
    mfa = 1'b0;
    @(posedge main_clk); #1;
    check({tag, " release moc"}, 32'(moc), 32'd0);
    check({tag, " release err"}, 32'(err), 32'd0);
    check({tag, " release data"}, data_out, held);
  endtask

  initial begin
    logic r;
    logic [1:0] s;
    int a;
    for (int i = 0; i < int'(DP); i++) begin
      model_mem[i]  = 8'($urandom);
      dut.memory[i] = model_mem[i];
    end
    model_mem[0] = 8'hE3; model_mem[1] = 8'hA0; model_mem[2] = 8'h10; model_mem[3] = 8'h05;
    for (int i = 0; i < 4; i++) dut.memory[i] = model_mem[i];
    #12;
    check("reset moc", 32'(moc), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset data", data_out, 32'h0);
    @(posedge main_clk); #1;
    reset = 1'b1;

    req(1'b1, 2'b10, 0, 32'h0, 0, "t1 word read");
    check("t1 value", data_out, 32'hE3A01005);

    req(1'b0, 2'b10, 508, 32'hDEADBEEF, 0, "t2 word write");
    req(1'b1, 2'b00, 509, 32'h0, 0, "t2 byte read");
    check("t2 byte value", data_out, 32'h000000AD);
    req(1'b1, 2'b01, 510, 32'h0, 0, "t2 half read");
    check("t2 half value", data_out, 32'h0000BEEF);

    req(1'b0, 2'b10, 4, 32'h11223344, 0, "t3 word write");
    req(1'b0, 2'b00, 6, 32'h0000007F, 0, "t3 byte write");
    req(1'b1, 2'b10, 4, 32'h0, 0, "t3 word read");
    check("t3 value", data_out, 32'h11227F44);

    req(1'b1, 2'b01, 3, 32'h0, 0, "t4 half misaligned");
    req(1'b0, 2'b10, 2, 32'hCAFEF00D, 0, "t4 word misaligned");
    req(1'b0, 2'b11, 8, 32'h12345678, 0, "t4 reserved size");
    check_mem("t4 memory");

    // Abort by dropping mfa during WAIT
    mfa = 1'b1; rw = 1'b0; size = 2'b10; address = AW'(16); data_in = 32'hA5A5A5A5;
    @(posedge main_clk); #1;
    mfa = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge main_clk); #1;
      check("t5 abort moc", 32'(moc), 32'd0);
    end
    check_mem("t5 abort memory");

    // Abort by reset pulse during WAIT of a write
    mfa = 1'b1; rw = 1'b0; size = 2'b10; address = AW'(20); data_in = 32'h5A5A5A5A;
    @(posedge main_clk); #1;
    reset = 1'b0;
    #2;
    check("t5 reset moc", 32'(moc), 32'd0);
    check("t5 reset err", 32'(err), 32'd0);
    check("t5 reset data", data_out, 32'h0);
    @(posedge main_clk); #1;
    mfa = 1'b0; reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge main_clk); #1;
      check("t5 post-reset moc", 32'(moc), 32'd0);
    end
    check_mem("t5 reset memory");

    req(1'b1, 2'b10, 4, 32'h0, 5, "t6 held read");
    req(1'b1, 2'b01, 0, 32'h0, 0, "t6 next read");
    check("t6 next value", data_out, 32'h0000E3A0);

    for (int n = 0; n < 60; n++) begin
      r = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a = $urandom_range(0, DP - 1);
      if (s != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~((1 << s) - 1);
      req(r, s, a, $urandom, $urandom_range(0, 3), "rand");
    end
    check_mem("rand memory");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
